// File: rtl/rtc_pkg.sv
// rtc_pkg: shared widths, limits, alarm state encoding and time helpers for
// the rtc_ctrl block.
// Optional feature macro: RTC_CTRL_SNOOZE_EN adds the SNOOZE alarm state.
package rtc_pkg;
  localparam int SEC_W = 6;
  localparam int MIN_W = 6;
  localparam int HR_W  = 5;

  localparam logic [SEC_W-1:0] MAX_SEC = 6'd59;
  localparam logic [MIN_W-1:0] MAX_MIN = 6'd59;
  localparam logic [HR_W-1:0]  MAX_HR  = 5'd23;

`ifdef RTC_CTRL_SNOOZE_EN
  typedef enum logic [1:0] {ALM_OFF, ALM_ARMED, ALM_RING, ALM_SNOOZE} alm_state_t;
`else
  typedef enum logic [1:0] {ALM_OFF, ALM_ARMED, ALM_RING} alm_state_t;
`endif

  typedef struct packed {
    logic [HR_W-1:0]  hh;
    logic [MIN_W-1:0] mm;
    logic [SEC_W-1:0] ss;
  } rtc_time_t;

  localparam rtc_time_t DAY_END = '{hh: MAX_HR, mm: MAX_MIN, ss: MAX_SEC};

  function automatic logic time_ok(input rtc_time_t t);
    return (t.hh <= MAX_HR) && (t.mm <= MAX_MIN) && (t.ss <= MAX_SEC);
  endfunction

  // One-second advance with carries; 23:59:59 rolls to 00:00:00.
  function automatic rtc_time_t time_inc(input rtc_time_t t);
    rtc_time_t r;
    r = t;
    if (t.ss == MAX_SEC) begin
      r.ss = '0;
      if (t.mm == MAX_MIN) begin
        r.mm = '0;
        r.hh = (t.hh == MAX_HR) ? '0 : t.hh + 5'd1;
      end else begin
        r.mm = t.mm + 6'd1;
      end
    end else begin
      r.ss = t.ss + 6'd1;
    end
    return r;
  endfunction
endpackage

// File: rtl/rtc_time_core.sv
// rtc_time_core: hh:mm:ss counter chain with a load port.
// Ports: clk, reset_n (async low); tick advances one second; load/load_time
// overrides the count (load has priority); cur is the registered time, nxt
// is cur advanced by one second (lets the caller look ahead for alarm
// matches); day_wrap pulses on the 23:59:59 -> 00:00:00 step.
module rtc_time_core
  import rtc_pkg::*;
(
  input  logic      clk,
  input  logic      reset_n,
  input  logic      tick,
  input  logic      load,
  input  rtc_time_t load_time,
  output rtc_time_t cur,
  output rtc_time_t nxt,
  output logic      day_wrap
);
  assign nxt = time_inc(cur);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cur      <= '0;
      day_wrap <= 1'b0;
    end else begin
      day_wrap <= 1'b0;
      if (load) begin
        cur <= load_time;
      end else if (tick) begin
        cur      <= nxt;
        day_wrap <= (cur == DAY_END);
      end
    end
  end
endmodule

// File: rtl/rtc_ctrl.sv
// rtc_ctrl: timekeeping controller. Runs the time counter from a 1 Hz tick,
// accepts range-checked time-set requests over a valid/ready handshake,
// holds an hh:mm alarm and runs the alarm FSM (OFF/ARMED/RING[/SNOOZE]).
// Ports: clk, reset_n (async low); tick; set_valid/set_hh/set_mm/set_ss,
// set_ready, set_err; alm_valid/alm_hh/alm_mm; alarm_en, alarm_ack,
// snooze (RTC_CTRL_SNOOZE_EN only); seconds/minutes/hours, alarm_ring,
// day_wrap. All outputs are registered.
// Optional feature macro: RTC_CTRL_SNOOZE_EN.
module rtc_ctrl
  import rtc_pkg::*;
#(
  parameter int RING_SECONDS   = 30,
  parameter int SNOOZE_MINUTES = 5
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             tick,
  input  logic             set_valid,
  input  logic [HR_W-1:0]  set_hh,
  input  logic [MIN_W-1:0] set_mm,
  input  logic [SEC_W-1:0] set_ss,
  output logic             set_ready,
  output logic             set_err,
  input  logic             alm_valid,
  input  logic [HR_W-1:0]  alm_hh,
  input  logic [MIN_W-1:0] alm_mm,
  input  logic             alarm_en,
  input  logic             alarm_ack,
`ifdef RTC_CTRL_SNOOZE_EN
  input  logic             snooze,
`endif
  output logic [SEC_W-1:0] seconds,
  output logic [MIN_W-1:0] minutes,
  output logic [HR_W-1:0]  hours,
  output logic             alarm_ring,
  output logic             day_wrap
);
  if (RING_SECONDS < 1 || RING_SECONDS > 255) begin : g_bad_ring
    $error("RING_SECONDS out of range");
  end
  if (SNOOZE_MINUTES < 1 || SNOOZE_MINUTES > 59) begin : g_bad_snz
    $error("SNOOZE_MINUTES out of range");
  end

  localparam logic [7:0] RING_LAST = 8'(RING_SECONDS - 1);

  rtc_time_t  cur, nxt, set_t, alm_t, alm_q;
  alm_state_t state;
  logic [7:0] ring_cnt;
  logic       set_xfer, set_ok, alm_ok, tick_run, alm_hit, ring_done;

  assign set_t    = '{hh: set_hh, mm: set_mm, ss: set_ss};
  assign alm_t    = '{hh: alm_hh, mm: alm_mm, ss: '0};
  assign set_xfer = set_valid & set_ready;
  assign set_ok   = time_ok(set_t);
  assign alm_ok   = alm_valid & time_ok(alm_t);
  // Any transfer, valid or not, swallows a coincident tick.
  assign tick_run = tick & ~set_xfer;
  // Only a counted tick can reach the alarm time; a load never triggers it.
  assign alm_hit  = tick_run && (nxt == alm_q);
  assign ring_done = tick_run && (ring_cnt == RING_LAST);

  rtc_time_core u_core (
    .clk      (clk),
    .reset_n  (reset_n),
    .tick     (tick_run),
    .load     (set_xfer & set_ok),
    .load_time(set_t),
    .cur      (cur),
    .nxt      (nxt),
    .day_wrap (day_wrap)
  );

  assign seconds = cur.ss;
  assign minutes = cur.mm;
  assign hours   = cur.hh;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      set_ready <= 1'b1;
      set_err   <= 1'b0;
      alm_q     <= '0;
    end else begin
      set_ready <= ~set_xfer;
      set_err   <= (set_xfer & ~set_ok) | (alm_valid & ~alm_ok);
      if (alm_ok) alm_q <= alm_t;
    end
  end

`ifdef RTC_CTRL_SNOOZE_EN
  localparam logic [11:0] SNZ_LAST = 12'(SNOOZE_MINUTES * 60 - 1);
  logic [11:0] snz_cnt;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= ALM_OFF;
      alarm_ring <= 1'b0;
      ring_cnt   <= '0;
`ifdef RTC_CTRL_SNOOZE_EN
      snz_cnt    <= '0;
`endif
    end else if (!alarm_en) begin
      state      <= ALM_OFF;
      alarm_ring <= 1'b0;
    end else begin
      case (state)
        ALM_OFF: state <= ALM_ARMED;
        ALM_ARMED: if (alm_hit) begin
          state      <= ALM_RING;
          alarm_ring <= 1'b1;
          ring_cnt   <= '0;
        end
        ALM_RING: begin
          if (alarm_ack || alm_ok || ring_done) begin
            state      <= ALM_ARMED;
            alarm_ring <= 1'b0;
`ifdef RTC_CTRL_SNOOZE_EN
          end else if (snooze) begin
            state      <= ALM_SNOOZE;
            alarm_ring <= 1'b0;
            snz_cnt    <= '0;
`endif
          end else if (tick_run) begin
            ring_cnt <= ring_cnt + 8'd1;
          end
        end
`ifdef RTC_CTRL_SNOOZE_EN
        ALM_SNOOZE: begin
          if (alarm_ack) begin
            state <= ALM_ARMED;
          end else if (tick_run) begin
            if (snz_cnt == SNZ_LAST) begin
              state      <= ALM_RING;
              alarm_ring <= 1'b1;
              ring_cnt   <= '0;
            end else begin
              snz_cnt <= snz_cnt + 12'd1;
            end
          end
        end
`endif
        default: begin
          state      <= ALM_OFF;
          alarm_ring <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_rtc_ctrl.sv
// tb_rtc_ctrl: directed stimulus; expected output snapshots are queued by
// the stimulus process and compared by an independent negedge monitor.
module tb_rtc_ctrl;
  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       tick = 1'b0;
  logic       set_valid = 1'b0;
  logic [4:0] set_hh = '0;
  logic [5:0] set_mm = '0, set_ss = '0;
  logic       set_ready, set_err;
  logic       alm_valid = 1'b0;
  logic [4:0] alm_hh = '0;
  logic [5:0] alm_mm = '0;
  logic       alarm_en = 1'b0, alarm_ack = 1'b0;
`ifdef RTC_CTRL_SNOOZE_EN
  logic       snooze = 1'b0;
`endif
  logic [5:0] seconds, minutes;
  logic [4:0] hours;
  logic       alarm_ring, day_wrap;

  int errors = 0;
  int checks = 0;

  typedef struct {
    string      name;
    logic [4:0] hh;
    logic [5:0] mm, ss;
    logic       ring, wrap, rdy, err;
  } exp_t;
  exp_t q[$];

  rtc_ctrl #(.RING_SECONDS(30), .SNOOZE_MINUTES(5)) dut (
    .clk(clk), .reset_n(reset_n), .tick(tick),
    .set_valid(set_valid), .set_hh(set_hh), .set_mm(set_mm), .set_ss(set_ss),
    .set_ready(set_ready), .set_err(set_err),
    .alm_valid(alm_valid), .alm_hh(alm_hh), .alm_mm(alm_mm),
    .alarm_en(alarm_en), .alarm_ack(alarm_ack),
`ifdef RTC_CTRL_SNOOZE_EN
    .snooze(snooze),
`endif
    .seconds(seconds), .minutes(minutes), .hours(hours),
    .alarm_ring(alarm_ring), .day_wrap(day_wrap)
  );

  always #5 clk = ~clk;

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Monitor: one queued snapshot compared per falling edge.
  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      checks++;
      if (hours !== e.hh || minutes !== e.mm || seconds !== e.ss ||
          alarm_ring !== e.ring || day_wrap !== e.wrap ||
          set_ready !== e.rdy || set_err !== e.err) begin
        errors++;
        $display("FAIL %s: got %0d:%0d:%0d ring=%b wrap=%b rdy=%b err=%b, want %0d:%0d:%0d ring=%b wrap=%b rdy=%b err=%b",
                 e.name, hours, minutes, seconds, alarm_ring, day_wrap, set_ready, set_err,
                 e.hh, e.mm, e.ss, e.ring, e.wrap, e.rdy, e.err);
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_s(input string n, input int hh, input int mm, input int ss,
                          input bit ring, input bit wrap, input bit rdy, input bit err);
    exp_t e;
    e.name = n; e.hh = 5'(hh); e.mm = 6'(mm); e.ss = 6'(ss);
    e.ring = ring; e.wrap = wrap; e.rdy = rdy; e.err = err;
    q.push_back(e);
  endtask

  task automatic do_set(input int hh, input int mm, input int ss);
    set_valid = 1'b1; set_hh = 5'(hh); set_mm = 6'(mm); set_ss = 6'(ss);
    cyc();
    set_valid = 1'b0;
  endtask

  task automatic ticks(input int n);
    tick = 1'b1;
    repeat (n) cyc();
    tick = 1'b0;
  endtask

  initial begin
    #1;
    expect_s("reset_state", 0, 0, 0, 0, 0, 1, 0);
    @(negedge clk);
    cyc();
    reset_n = 1'b1;
    cyc();

    ticks(3661);
    expect_s("count_3661", 1, 1, 1, 0, 0, 1, 0);
    cyc();

    do_set(23, 59, 59);
    expect_s("set_235959", 23, 59, 59, 0, 0, 0, 0);
    tick = 1'b1; cyc(); tick = 1'b0;
    expect_s("day_wrap_pulse", 0, 0, 0, 0, 1, 1, 0);
    cyc();
    expect_s("day_wrap_clear", 0, 0, 0, 0, 0, 1, 0);
    cyc();

    tick = 1'b1; do_set(12, 34, 56); tick = 1'b0;
    expect_s("set_beats_tick", 12, 34, 56, 0, 0, 0, 0);
    cyc();
    expect_s("ready_back", 12, 34, 56, 0, 0, 1, 0);
    do_set(24, 0, 0);
    expect_s("set_err_pulse", 12, 34, 56, 0, 0, 0, 1);
    cyc();
    expect_s("set_err_clear", 12, 34, 56, 0, 0, 1, 0);

    alm_valid = 1'b1; alm_hh = 5'd7; alm_mm = 6'd30; alarm_en = 1'b1;
    cyc();
    alm_valid = 1'b0;
    do_set(7, 29, 59);
    tick = 1'b1; cyc(); tick = 1'b0;
    expect_s("alarm_ring", 7, 30, 0, 1, 0, 1, 0);
    alarm_ack = 1'b1; cyc(); alarm_ack = 1'b0;
    expect_s("alarm_ack", 7, 30, 0, 0, 0, 1, 0);
    cyc();

    do_set(7, 30, 0);
    expect_s("set_no_ring", 7, 30, 0, 0, 0, 0, 0);
    ticks(1);
    expect_s("tick_no_ring", 7, 30, 1, 0, 0, 1, 0);

    do_set(7, 29, 59);
    ticks(1);
    expect_s("ring_again", 7, 30, 0, 1, 0, 1, 0);
    ticks(29);
    expect_s("ring_29_ticks", 7, 30, 29, 1, 0, 1, 0);
    ticks(1);
    expect_s("ring_timeout", 7, 30, 30, 0, 0, 1, 0);
    cyc();

    do_set(7, 29, 59);
    ticks(1);
    expect_s("ring_for_disable", 7, 30, 0, 1, 0, 1, 0);
    alarm_en = 1'b0; cyc();
    expect_s("alarm_en_off", 7, 30, 0, 0, 0, 1, 0);
    alarm_en = 1'b1; cyc();

    alm_valid = 1'b1; alm_hh = 5'd25; alm_mm = 6'd0; cyc(); alm_valid = 1'b0;
    expect_s("bad_alarm_err", 7, 30, 0, 0, 0, 1, 1);
    cyc();

    do_set(7, 29, 59);
    ticks(1);
    expect_s("ring_for_reset", 7, 30, 0, 1, 0, 1, 0);
    @(negedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    expect_s("reset_mid_ring", 0, 0, 0, 0, 0, 1, 0);
    cyc();
    cyc();
    reset_n = 1'b1;
    cyc();

`ifdef RTC_CTRL_SNOOZE_EN
    alm_valid = 1'b1; alm_hh = 5'd7; alm_mm = 6'd30; cyc(); alm_valid = 1'b0;
    do_set(7, 29, 59);
    ticks(1);
    expect_s("snz_ring", 7, 30, 0, 1, 0, 1, 0);
    snooze = 1'b1; cyc(); snooze = 1'b0;
    expect_s("snz_stop", 7, 30, 0, 0, 0, 1, 0);
    ticks(299);
    expect_s("snz_299", 7, 34, 59, 0, 0, 1, 0);
    ticks(1);
    expect_s("snz_rering", 7, 35, 0, 1, 0, 1, 0);
    snooze = 1'b1; alarm_ack = 1'b1; cyc(); snooze = 1'b0; alarm_ack = 1'b0;
    expect_s("snz_ack_wins", 7, 35, 0, 0, 0, 1, 0);
    ticks(300);
    expect_s("snz_stays_armed", 7, 40, 0, 0, 0, 1, 0);
`endif

    cyc();
    @(negedge clk);
    #1;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL queue_drain: %0d pending, want 0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
